stream_fifo: RTL and testbench
==============================

STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, payload width in bits.
REQ-002 SHALL provide parameter DEPTH, default 8, entry count; power of two, >= 2.
REQ-003 SHALL provide parameter AF_THRESH, default DEPTH-2, almost-full threshold in entries.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  DATA_W  write payload.
REQ-007 SHALL have port in_valid  input  1  write request.
REQ-008 SHALL have port in_ready  output  1  space available.
REQ-009 SHALL have port out_data  output  DATA_W  head-of-queue payload.
REQ-010 SHALL have port out_valid  output  1  queue non-empty.
REQ-011 SHALL have port out_ready  input  1  consumer accepts.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port almost_full  output  1  occupancy >= AF_THRESH (STREAM_FIFO_ALMOST_FULL_EN only).

Function
REQ-014 SHALL accept a push when in_valid && in_ready on a rising clk edge.
REQ-015 SHALL complete a pop when out_valid && out_ready on a rising clk edge.
REQ-016 SHALL drive in_ready = (count != DEPTH), registered-equivalent; no combinational path from out_ready.
REQ-017 SHALL drive out_valid = (count != 0); out_data SHALL be the oldest stored entry (first-word fall-through).
REQ-018 SHALL have push-to-out_valid latency of exactly 1 cycle when empty.
REQ-019 SHALL, on simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and preserve order.
REQ-020 SHALL, when full, ignore in_valid (in_ready=0) even if a pop occurs that cycle; in_ready rises the following cycle.
REQ-021 SHALL, when empty, not pop; out_data value is don't-care while out_valid=0.
REQ-022 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated entry.
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL update count as count + push - pop, never exceeding DEPTH nor going below 0.

Reset
REQ-025 SHALL, while rst_n=0, force pointers and count to 0 immediately, regardless of clk.
REQ-026 SHALL present reset outputs: out_valid=0, in_ready=1, count=0, almost_full=0 (AF_THRESH>0).
REQ-027 SHALL discard all stored entries on reset mid-operation; storage array not reset.
REQ-028 SHALL deassert reset synchronously to internal state; first push accepted on first edge with rst_n=1.

Configuration
REQ-029 SHALL compile almost_full port and logic only when macro STREAM_FIFO_ALMOST_FULL_EN is defined.
REQ-030 SHALL, with STREAM_FIFO_ALMOST_FULL_EN, assert almost_full registered from next-state count (same-cycle as count).
REQ-031 SHALL, without STREAM_FIFO_ALMOST_FULL_EN, omit the almost_full port and parameter checks on AF_THRESH.

Structure
REQ-032 SHALL take DATA_W default, DEPTH default and the count-width function from shared package sv_pkg.
REQ-033 SHALL place storage in sub-module stream_fifo_mem (1 write port, 1 async read port, no reset).
REQ-034 SHALL flag illegal DEPTH (non-power-of-two or < 2) with an elaboration-time error.

Verification (DEPTH=4, DATA_W=8, AF_THRESH=2)
REQ-035 SHALL cover: reset, push 0x11 -> next cycle out_valid=1, out_data=0x11, count=1.
REQ-036 SHALL cover: push 0xA0..0xA3, out_ready=0 -> count=4, in_ready=0; 5th push 0xA4 ignored; drain yields A0,A1,A2,A3.
REQ-037 SHALL cover: full, in_valid=1 and out_ready=1 same cycle -> pop A0 only, count=3, in_ready=1 next cycle.
REQ-038 SHALL cover: continuous push+pop for 10 cycles with count=2 -> count stays 2, pointers wrap, data in order.
REQ-039 SHALL cover: rst_n low with count=3 -> count=0, out_valid=0, in_ready=1 without clock edge.
REQ-040 SHALL cover: STREAM_FIFO_ALMOST_FULL_EN defined, pushes to count=2 -> almost_full=1; pop to count=1 -> 0.

Source files
------------

// File: rtl/sv_pkg.sv
// Shared definitions for the stream FIFO slice.
// Provides the default payload width and depth, the occupancy-counter
// width helper, and a power-of-two test used for elaboration checks.
package sv_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned DEPTH_DEFAULT  = 8;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Storage array for stream_fifo: one synchronous write port and one
// asynchronous read port. The array is deliberately not reset.
// Ports:
//   clk_i      - write clock
//   wr_en_i    - write strobe
//   wr_addr_i  - write address
//   wr_data_i  - write payload
//   rd_addr_i  - read address
//   rd_data_o  - read payload (combinational from rd_addr_i)
module stream_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/stream_fifo.sv
// First-word fall-through stream FIFO with valid/ready handshakes on both
// sides and an occupancy count.
// Optional feature: define STREAM_FIFO_ALMOST_FULL_EN to add the almost_full
// output (occupancy >= AF_THRESH, registered alongside count).
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   in_data     - write payload
//   in_valid    - write request
//   in_ready    - space available (depends on stored count only)
//   out_data    - oldest stored entry
//   out_valid   - FIFO non-empty
//   out_ready   - consumer accepts head entry
//   count       - current occupancy, 0..DEPTH
//   almost_full - occupancy >= AF_THRESH (only with STREAM_FIFO_ALMOST_FULL_EN)
module stream_fifo
    import sv_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEFAULT,
    parameter int unsigned DEPTH     = DEPTH_DEFAULT,
    parameter int unsigned AF_THRESH = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [cnt_w(DEPTH)-1:0]   count
`ifdef STREAM_FIFO_ALMOST_FULL_EN
    ,
    output logic                      almost_full
`endif
);

    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned AW = CW - 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // in_ready comes from the stored count only, so a pop while full does
    // not open the write side until the following cycle.
    assign in_ready  = (count_q != FullCount);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointer width equals log2(DEPTH), so increments wrap naturally.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef STREAM_FIFO_ALMOST_FULL_EN
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("stream_fifo: AF_THRESH must be in 1..DEPTH");
    end

    localparam logic [CW-1:0] AfCount = CW'(AF_THRESH);
    logic almost_full_q;

    // Registered from next-state count so it changes on the same edge as count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (count_d >= AfCount);
        end
    end

    assign almost_full = almost_full_q;
`else
    logic unused_af_thresh;
    assign unused_af_thresh = ^AF_THRESH;
`endif

    stream_fifo_mem #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i    (clk),
        .wr_en_i  (push),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(in_data),
        .rd_addr_i(rd_ptr_q),
        .rd_data_o(out_data)
    );

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo (DEPTH=4, DATA_W=8,
// AF_THRESH=2). Define STREAM_FIFO_ALMOST_FULL_EN to include almost_full.
module tb_stream_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
`ifdef STREAM_FIFO_ALMOST_FULL_EN
    logic       almost_full;
`endif

    int n_cmp;
    int n_err;

    stream_fifo #(
        .DATA_W   (8),
        .DEPTH    (4),
        .AF_THRESH(2)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
`ifdef STREAM_FIFO_ALMOST_FULL_EN
        ,
        .almost_full(almost_full)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #11;
        check_eq("reset_count", 32'(count), 32'd0);
        check_eq("reset_out_valid", 32'(out_valid), 32'd0);
        check_eq("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef STREAM_FIFO_ALMOST_FULL_EN
        check_eq("reset_almost_full", 32'(almost_full), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Single push: visible one cycle later.
        push_one(8'h11);
        check_eq("first_out_valid", 32'(out_valid), 32'd1);
        check_eq("first_out_data", 32'(out_data), 32'h11);
        check_eq("first_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("first_pop_count", 32'(count), 32'd0);
        check_eq("first_pop_empty", 32'(out_valid), 32'd0);

        // Fill to full.
        for (int i = 0; i < 4; i++) begin
            push_one(8'hA0 + 8'(i));
`ifdef STREAM_FIFO_ALMOST_FULL_EN
            check_eq("fill_almost_full", 32'(almost_full), (i >= 1) ? 32'd1 : 32'd0);
`endif
        end
        check_eq("full_count", 32'(count), 32'd4);
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        push_one(8'hA4);
        check_eq("overflow_count", 32'(count), 32'd4);
        check_eq("full_hold_data", 32'(out_data), 32'hA0);

        // Full with push and pop together: only the pop happens.
        in_data   = 8'hA5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check_eq("full_pop_head", 32'(out_data), 32'hA0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("full_pop_count", 32'(count), 32'd3);
        check_eq("full_pop_in_ready", 32'(in_ready), 32'd1);

        // Drain the remainder in order.
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check_eq("drain_data", 32'(out_data), 32'hA0 + 32'(i));
            step();
        end
        out_ready = 1'b0;
        check_eq("drain_count", 32'(count), 32'd0);
        check_eq("drain_empty", 32'(out_valid), 32'd0);

        // Steady push+pop at count=2; 12 entries wrap the pointers.
        push_one(8'hB0);
        push_one(8'hB1);
        for (int i = 0; i < 10; i++) begin
            in_data   = 8'hB2 + 8'(i);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            check_eq("stream_data", 32'(out_data), 32'hB0 + 32'(i));
            step();
            check_eq("stream_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        for (int i = 10; i < 12; i++) begin
            check_eq("stream_tail", 32'(out_data), 32'hB0 + 32'(i));
            step();
        end
        out_ready = 1'b0;
        check_eq("stream_end_count", 32'(count), 32'd0);

        // Asynchronous reset mid-operation, checked before any clock edge.
        push_one(8'hC0);
        push_one(8'hC1);
        push_one(8'hC2);
        check_eq("pre_reset_count", 32'(count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_count", 32'(count), 32'd0);
        check_eq("async_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        push_one(8'hD0);
        check_eq("post_rst_count", 32'(count), 32'd1);
        check_eq("post_rst_data", 32'(out_data), 32'hD0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("post_rst_drain", 32'(count), 32'd0);

`ifdef STREAM_FIFO_ALMOST_FULL_EN
        push_one(8'hE0);
        check_eq("af_at_1", 32'(almost_full), 32'd0);
        push_one(8'hE1);
        check_eq("af_at_2", 32'(almost_full), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("af_pop_count", 32'(count), 32'd1);
        check_eq("af_after_pop", 32'(almost_full), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
